// File: rtl/vx_hpdcache_lane_arbiter.sv
// vx_hpdcache_lane_arbiter
//   Merges NUM_REQS core lanes onto the single HPDCache adapter request channel.
//   Reads and flushes get a tid from a pool. Writes carry tid 0 and expect no response.
//   Responses cannot be back-pressured, so they land in a tid-deep FIFO.
//   Each response is routed back to its lane with that lane's original core tag.
//   Optional feature macro: VX_HPDCACHE_FLUSH_DRAIN_EN
//     Defined: a flush waits until nothing is outstanding, then blocks every lane
//     until its own response has been consumed.
//     Undefined: a flush is arbitrated like a read.

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

// Per-lane request eligibility and response-valid decode.
module vx_hpdcache_lane_arbiter_lane #(
    parameter int                LANE_W  = 2,
    parameter logic [LANE_W-1:0] LANE_ID = '0
) (
    input  logic              req_valid_i,
    input  logic              req_rw_i,
    input  logic              req_flush_i,
    input  logic              tid_avail_i,
    input  logic              flush_ok_i,
    input  logic              blocked_i,
    input  logic              rsp_head_valid_i,
    input  logic [LANE_W-1:0] rsp_head_lane_i,
    output logic              elig_o,
    output logic              rsp_valid_o
);
    // Writes never need a tid. A flush may have a stricter gate than a read.
    assign elig_o      = req_valid_i & ~blocked_i &
                         (req_rw_i | (req_flush_i ? flush_ok_i : tid_avail_i));
    assign rsp_valid_o = rsp_head_valid_i & (rsp_head_lane_i == LANE_ID);
endmodule

module vx_hpdcache_lane_arbiter #(
    parameter int NUM_REQS   = 4,
    parameter int ADDR_WIDTH = `MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = `XLEN,
    parameter int TAG_WIDTH  = 8,
    parameter int NUM_TIDS   = 8,
    parameter int TID_WIDTH  = $clog2(NUM_TIDS)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [NUM_REQS-1:0]                      core_req_valid_i,
    output logic [NUM_REQS-1:0]                      core_req_ready_o,
    input  logic [NUM_REQS-1:0]                      core_req_rw_i,
    input  logic [NUM_REQS-1:0]                      core_req_flush_i,
    input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]      core_req_addr_i,
    input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]      core_req_data_i,
    input  logic [NUM_REQS-1:0][DATA_WIDTH/8-1:0]    core_req_byteen_i,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]       core_req_tag_i,
    output logic [NUM_REQS-1:0]                      core_rsp_valid_o,
    input  logic [NUM_REQS-1:0]                      core_rsp_ready_i,
    output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]      core_rsp_data_o,
    output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]       core_rsp_tag_o,
    output logic                                     mem_req_valid_o,
    input  logic                                     mem_req_ready_i,
    output logic                                     mem_req_rw_o,
    output logic                                     mem_req_flush_o,
    output logic [ADDR_WIDTH-1:0]                    mem_req_addr_o,
    output logic [DATA_WIDTH-1:0]                    mem_req_data_o,
    output logic [DATA_WIDTH/8-1:0]                  mem_req_byteen_o,
    output logic [TID_WIDTH-1:0]                     mem_req_tag_o,
    input  logic                                     mem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]                    mem_rsp_data_i,
    input  logic [TID_WIDTH-1:0]                     mem_rsp_tag_i
);
    localparam int LANE_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    // tid table: busy bits are reset; the payload is only read while busy
    logic [NUM_TIDS-1:0]  busy_q;
    logic [LANE_W-1:0]    tbl_lane_q  [NUM_TIDS];
    logic [TAG_WIDTH-1:0] tbl_tag_q   [NUM_TIDS];
    logic [NUM_TIDS-1:0]  tbl_flush_q;

    // response FIFO: extra pointer bit tells full from empty
    logic [TID_WIDTH-1:0]  fifo_tid_q  [NUM_TIDS];
    logic [DATA_WIDTH-1:0] fifo_data_q [NUM_TIDS];
    logic [TID_WIDTH:0]    wptr_q, rptr_q, fifo_cnt;
    logic                  fifo_empty;

    logic [LANE_W-1:0]    rr_q;
    logic [NUM_REQS-1:0]  elig;
    logic                 gnt_vld;
    logic [LANE_W-1:0]    gnt_idx;
    logic                 mreq_hs, alloc, push, pop;
    logic                 tid_avail, flush_ok, blocked;
    logic [TID_WIDTH-1:0] free_tid, head_tid;
    logic [LANE_W-1:0]    head_lane;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_cnt   = wptr_q - rptr_q;
    assign head_tid   = fifo_tid_q[rptr_q[TID_WIDTH-1:0]];
    assign head_lane  = tbl_lane_q[head_tid];
    assign tid_avail  = ~&busy_q;

    // Lowest-index free tid, taken from the registered busy vector
    always_comb begin
        free_tid = '0;
        for (int t = NUM_TIDS - 1; t >= 0; t--)
            if (!busy_q[t]) free_tid = TID_WIDTH'(t);
    end

`ifdef VX_HPDCACHE_FLUSH_DRAIN_EN
    logic flush_pend_q;
    assign flush_ok = (busy_q == '0) & fifo_empty;
    assign blocked  = flush_pend_q | ~reset_n_i;

    // Outstanding flush: set when it issues, cleared when its response is consumed
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                            flush_pend_q <= 1'b0;
        else if (alloc && mem_req_flush_o)         flush_pend_q <= 1'b1;
        else if (pop && tbl_flush_q[head_tid])     flush_pend_q <= 1'b0;
    end
`else
    assign flush_ok = tid_avail;
    assign blocked  = ~reset_n_i;
`endif

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_lane
        vx_hpdcache_lane_arbiter_lane #(
            .LANE_W  (LANE_W),
            .LANE_ID (LANE_W'(g))
        ) u_lane (
            .req_valid_i      (core_req_valid_i[g]),
            .req_rw_i         (core_req_rw_i[g]),
            .req_flush_i      (core_req_flush_i[g]),
            .tid_avail_i      (tid_avail),
            .flush_ok_i       (flush_ok),
            .blocked_i        (blocked),
            .rsp_head_valid_i (~fifo_empty),
            .rsp_head_lane_i  (head_lane),
            .elig_o           (elig[g]),
            .rsp_valid_o      (core_rsp_valid_o[g])
        );
    end

    // Round-robin pick: the first eligible lane at or after rr_q
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (!gnt_vld && elig[(int'(rr_q) + k) % NUM_REQS]) begin
                gnt_vld = 1'b1;
                gnt_idx = LANE_W'((int'(rr_q) + k) % NUM_REQS);
            end
        end
    end

    // Granted lane passes straight through to the adapter channel
    always_comb begin
        core_req_ready_o          = '0;
        core_req_ready_o[gnt_idx] = gnt_vld & mem_req_ready_i;
        mem_req_valid_o           = gnt_vld;
        mem_req_rw_o              = core_req_rw_i[gnt_idx];
        mem_req_flush_o           = core_req_flush_i[gnt_idx];
        mem_req_addr_o            = core_req_addr_i[gnt_idx];
        mem_req_data_o            = core_req_data_i[gnt_idx];
        mem_req_byteen_o          = core_req_byteen_i[gnt_idx];
        mem_req_tag_o             = core_req_rw_i[gnt_idx] ? '0 : free_tid;
    end

    assign mreq_hs = mem_req_valid_o & mem_req_ready_i;
    assign alloc   = mreq_hs & ~mem_req_rw_o;
    assign push    = mem_rsp_valid_i & busy_q[mem_rsp_tag_i];
    assign pop     = ~fifo_empty & core_rsp_ready_i[head_lane];

    // Response payload is broadcast; only the owning lane sees valid
    always_comb begin
        for (int l = 0; l < NUM_REQS; l++) begin
            core_rsp_data_o[l] = tbl_flush_q[head_tid] ? '0
                                 : fifo_data_q[rptr_q[TID_WIDTH-1:0]];
            core_rsp_tag_o[l]  = tbl_tag_q[head_tid];
        end
    end

    // RR pointer moves past the winner only on an accepted request
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)   rr_q <= '0;
        else if (mreq_hs) rr_q <= (gnt_idx == LANE_W'(NUM_REQS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Busy bits: allocation and free never hit the same tid in one cycle
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_q <= '0;
        end else begin
            if (alloc) busy_q[free_tid] <= 1'b1;
            if (pop)   busy_q[head_tid] <= 1'b0;
        end
    end

    // tid table payload, captured on allocation
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            tbl_lane_q[free_tid]  <= gnt_idx;
            tbl_tag_q[free_tid]   <= core_req_tag_i[gnt_idx];
            tbl_flush_q[free_tid] <= mem_req_flush_o;
        end
    end

    // FIFO storage
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_tid_q[wptr_q[TID_WIDTH-1:0]]  <= mem_rsp_tag_i;
            fifo_data_q[wptr_q[TID_WIDTH-1:0]] <= mem_rsp_data_i;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // A response for a tid that is not outstanding is dropped and flagged
    a_spurious_rsp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_rsp_valid_i |-> busy_q[mem_rsp_tag_i])
        else $warning("spurious response, tid %0d not busy", mem_rsp_tag_i);

endmodule

// File: tb/tb_vx_hpdcache_lane_arbiter.sv
module tb_vx_hpdcache_lane_arbiter;
    localparam int NR = 4, AW = 32, DW = 32, TW = 8, NT = 8, IW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR-1:0]             req_vld, req_rdy, req_rw, req_flush;
    logic [NR-1:0][AW-1:0]     req_addr;
    logic [NR-1:0][DW-1:0]     req_data;
    logic [NR-1:0][DW/8-1:0]   req_be;
    logic [NR-1:0][TW-1:0]     req_tag;
    logic [NR-1:0]             rsp_vld, rsp_rdy;
    logic [NR-1:0][DW-1:0]     rsp_data;
    logic [NR-1:0][TW-1:0]     rsp_tag;
    logic                      m_vld, m_rdy, m_rw, m_flush;
    logic [AW-1:0]             m_addr;
    logic [DW-1:0]             m_data;
    logic [DW/8-1:0]           m_be;
    logic [IW-1:0]             m_tag;
    logic                      r_vld;
    logic [DW-1:0]             r_data;
    logic [IW-1:0]             r_tag;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vx_hpdcache_lane_arbiter #(
        .NUM_REQS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_TIDS(NT), .TID_WIDTH(IW)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .core_req_valid_i(req_vld), .core_req_ready_o(req_rdy), .core_req_rw_i(req_rw),
        .core_req_flush_i(req_flush), .core_req_addr_i(req_addr), .core_req_data_i(req_data),
        .core_req_byteen_i(req_be), .core_req_tag_i(req_tag),
        .core_rsp_valid_o(rsp_vld), .core_rsp_ready_i(rsp_rdy), .core_rsp_data_o(rsp_data),
        .core_rsp_tag_o(rsp_tag),
        .mem_req_valid_o(m_vld), .mem_req_ready_i(m_rdy), .mem_req_rw_o(m_rw),
        .mem_req_flush_o(m_flush), .mem_req_addr_o(m_addr), .mem_req_data_o(m_data),
        .mem_req_byteen_o(m_be), .mem_req_tag_o(m_tag),
        .mem_rsp_valid_i(r_vld), .mem_rsp_data_i(r_data), .mem_rsp_tag_i(r_tag)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req_vld = '0; req_rw = '0; req_flush = '0;
        req_addr = '0; req_data = '0; req_be = '1; req_tag = '0;
        rsp_rdy = '1; m_rdy = 1'b1;
        r_vld = 1'b0; r_data = '0; r_tag = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); idle(); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    // drive a response at the current negedge, hold for one cycle
    task automatic rsp(input int tid, input logic [DW-1:0] d);
        r_vld = 1'b1; r_tag = IW'(tid); r_data = d;
    endtask

    initial begin
        idle();
        #1;
        chk("rst_mreq_vld", m_vld, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---- four lanes read together, responses in reverse tid order
        @(negedge clk);
        req_vld = 4'hF;
        for (int i = 0; i < NR; i++) begin
            req_tag[i] = TW'(8'hA0 + i);
            req_addr[i] = AW'(32'h100 * i);
        end
        for (int k = 0; k < NR; k++) begin
            #1;
            chk("t1_tag", m_tag, k);
            chk("t1_gnt", req_rdy, 1 << k);
            chk("t1_addr", m_addr, 32'h100 * k);
            @(negedge clk);
            req_vld[k] = 1'b0;
        end
        for (int k = 0; k < 5; k++) begin
            if (k < 4) rsp(3 - k, DW'(32'hD0 + 3 - k));
            else r_vld = 1'b0;
            #1;
            if (k > 0) begin
                chk("t1_rsp_vld", rsp_vld, 1 << (4 - k));
                chk("t1_rsp_tag", rsp_tag[4 - k], 8'hA0 + 4 - k);
                chk("t1_rsp_data", rsp_data[4 - k], 32'hD0 + 4 - k);
            end
            @(negedge clk);
        end
        #1;
        chk("t1_rsp_idle", rsp_vld, 0);
        chk("t1_busy", dut.busy_q, 0);
        chk("t1_cnt", dut.fifo_cnt, 0);

        // ---- lane 1 exhausts the pool, a write still gets through
        @(negedge clk);
        req_vld = 4'b0010; req_tag[1] = 8'h10;
        for (int k = 0; k < NT; k++) begin
            #1;
            chk("t2_tag", m_tag, k);
            chk("t2_rdy", req_rdy, 4'b0010);
            @(negedge clk);
        end
        #1;
        chk("t2_stall_rdy", req_rdy[1], 0);
        chk("t2_stall_vld", m_vld, 0);
        @(negedge clk);
        req_vld[2] = 1'b1; req_rw[2] = 1'b1; req_addr[2] = 32'h200; req_data[2] = 32'h1234;
        #1;
        chk("t2_wr_rdy", req_rdy, 4'b0100);
        chk("t2_wr_tag", m_tag, 0);
        chk("t2_wr_rw", m_rw, 1);
        chk("t2_wr_data", m_data, 32'h1234);
        @(negedge clk);
        req_vld[2] = 1'b0; req_rw[2] = 1'b0;
        #1;
        chk("t2_stall2", req_rdy, 0);

        // ---- two responses parked behind a non-ready lane, then reset mid-flight
        @(negedge clk);
        rsp_rdy = 4'b1101;
        rsp(0, 32'h1);
        @(negedge clk);
        rsp(1, 32'h2);
        @(negedge clk);
        r_vld = 1'b0;
        #1;
        chk("t5_cnt_pre", dut.fifo_cnt, 2);
        chk("t5_rsp_pre", rsp_vld, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("t5_mreq_vld", m_vld, 0);
        chk("t5_req_rdy", req_rdy, 0);
        chk("t5_rsp_vld", rsp_vld, 0);
        chk("t5_cnt", dut.fifo_cnt, 0);
        chk("t5_busy", dut.busy_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_rdy = '1;
        #1;
        chk("t5_first_tag", m_tag, 0);
        chk("t5_first_rdy", req_rdy, 4'b0010);

        // ---- head-of-line blocking on lane 3
        do_reset();
        req_vld = 4'hF;
        for (int i = 0; i < NR; i++) req_tag[i] = TW'(8'hA0 + i);
        for (int k = 0; k < NR; k++) begin
            #1;
            chk("t3_tag", m_tag, k);
            @(negedge clk);
            req_vld[k] = 1'b0;
        end
        req_vld[0] = 1'b1; req_tag[0] = 8'h55;
        #1;
        chk("t3_tag4", m_tag, 4);
        chk("t3_rdy4", req_rdy, 4'b0001);
        @(negedge clk);
        req_vld = '0;
        rsp_rdy = 4'b0111;
        rsp(3, 32'h33);
        @(negedge clk);
        rsp(4, 32'h44);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_hold", rsp_vld, 4'b1000);
            if (c == 0) chk("t3_hold_tag", rsp_tag[3], 8'hA3);
            if (c == 1) chk("t3_cnt2", dut.fifo_cnt, 2);
            if (c == 4) rsp_rdy = '1;
            @(negedge clk);
            r_vld = 1'b0;
        end
        #1;
        chk("t3_next_vld", rsp_vld, 4'b0001);
        chk("t3_next_tag", rsp_tag[0], 8'h55);
        chk("t3_next_data", rsp_data[0], 32'h44);
        chk("t3_cnt1", dut.fifo_cnt, 1);
        @(negedge clk);
        #1;
        chk("t3_empty", rsp_vld, 0);

        // ---- flush with two reads outstanding
        do_reset();
        req_vld = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        req_vld = '0;
`ifdef VX_HPDCACHE_FLUSH_DRAIN_EN
        req_vld[2] = 1'b1; req_flush[2] = 1'b1; req_tag[2] = 8'hF2;
        rsp(0, 32'h11);
        #1;
        chk("t4_wait0", m_vld, 0);
        @(negedge clk);
        rsp(1, 32'h12);
        #1;
        chk("t4_wait1", m_vld, 0);
        @(negedge clk);
        r_vld = 1'b0;
        #1;
        chk("t4_wait2", m_vld, 0);
        @(negedge clk);
        #1;
        chk("t4_fl_vld", m_vld, 1);
        chk("t4_fl_flush", m_flush, 1);
        chk("t4_fl_tag", m_tag, 0);
        chk("t4_fl_rdy", req_rdy, 4'b0100);
        @(negedge clk);
        req_vld = 4'b0001; req_flush[2] = 1'b0;
        rsp(0, 32'hBEEF);
        #1;
        chk("t4_blk0", m_vld, 0);
        @(negedge clk);
        r_vld = 1'b0;
        #1;
        chk("t4_blk1", m_vld, 0);
        chk("t4_frsp_vld", rsp_vld, 4'b0100);
        chk("t4_frsp_data", rsp_data[2], 0);
        chk("t4_frsp_tag", rsp_tag[2], 8'hF2);
        @(negedge clk);
        #1;
        chk("t4_rd_vld", m_vld, 1);
        chk("t4_rd_tag", m_tag, 0);
        chk("t4_rd_rdy", req_rdy, 4'b0001);
`else
        req_vld = 4'b0101; req_flush[2] = 1'b1; req_tag[2] = 8'hF2; req_tag[0] = 8'h60;
        #1;
        chk("t4_fl_flush", m_flush, 1);
        chk("t4_fl_tag", m_tag, 2);
        chk("t4_fl_rdy", req_rdy, 4'b0100);
        @(negedge clk);
        req_vld[2] = 1'b0; req_flush[2] = 1'b0;
        #1;
        chk("t4_rd_tag", m_tag, 3);
        chk("t4_rd_rdy", req_rdy, 4'b0001);
        @(negedge clk);
        req_vld = '0;
        rsp(2, 32'hBEEF);
        @(negedge clk);
        r_vld = 1'b0;
        #1;
        chk("t4_frsp_vld", rsp_vld, 4'b0100);
        chk("t4_frsp_data", rsp_data[2], 0);
        chk("t4_frsp_tag", rsp_tag[2], 8'hF2);
`endif
        @(negedge clk);
        req_vld = '0;

        // ---- spurious response is dropped
        do_reset();
        rsp(6, 32'h66);
        @(negedge clk);
        r_vld = 1'b0;
        #1;
        chk("t6_rsp_vld", rsp_vld, 0);
        chk("t6_cnt", dut.fifo_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
